// File: rtl/fwrisc_mds_pkg.sv
// Shared definitions for the multiply/divide/shift issue path and the
// fwrisc_mul_div_shift unit it feeds.
package fwrisc_mds_pkg;

  localparam logic [3:0] OP_SLL   = 4'd0;
  localparam logic [3:0] OP_SRL   = 4'd1;
  localparam logic [3:0] OP_SRA   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULH  = 4'd4;  // unsigned x unsigned, high word
  localparam logic [3:0] OP_MULS  = 4'd5;
  localparam logic [3:0] OP_MULSH = 4'd6;  // signed x signed, high word
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_REM   = 4'd8;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRL    = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mds_state_e;

  // In the M group, funct3[2] selects divide/remainder and funct3[1] remainder.
  function automatic logic f3_is_divrem(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] funct3);
    return funct3[2] & funct3[1];
  endfunction

endpackage

// File: rtl/fwrisc_mds_issue_if.sv
// Request, unit and writeback signals between the core and the MDS issue block.
interface fwrisc_mds_issue_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_shift;
  logic [2:0]  req_funct3;
  logic        req_sra;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;

  logic        mds_valid;
  logic [3:0]  mds_op;
  logic [31:0] mds_a;
  logic [31:0] mds_b;
  logic [31:0] mds_out;
  logic        mds_out_valid;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic        busy;

  modport slave (
    input  req_valid, req_shift, req_funct3, req_sra, req_a, req_b, req_rd,
    output req_ready,
    output mds_valid, mds_op, mds_a, mds_b,
    input  mds_out, mds_out_valid,
    output wb_valid, wb_rd, wb_data, wb_err, busy,
    input  wb_ready
  );

  modport master (
    output req_valid, req_shift, req_funct3, req_sra, req_a, req_b, req_rd,
    input  req_ready,
    input  mds_valid, mds_op, mds_a, mds_b,
    output mds_out, mds_out_valid,
    input  wb_valid, wb_rd, wb_data, wb_err, busy,
    output wb_ready
  );

endinterface

// File: rtl/fwrisc_mds_decode.sv
// Combinational decode of a shift/M-extension request into a unit op code,
// plus detection of cases that complete without the unit.
module fwrisc_mds_decode
  import fwrisc_mds_pkg::*;
(
  input  logic        shift,
  input  logic [2:0]  funct3,
  input  logic        sra,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd,
  output logic [3:0]  op,
  output logic        is_local,
  output logic [31:0] local_data,
  output logic        local_err
);

  logic supported_s;
  logic divrem_s;
  logic rem_s;
  logic signed_div_s;

  always_comb begin
    divrem_s     = !shift && f3_is_divrem(funct3);
    rem_s        = !shift && f3_is_rem(funct3);
    signed_div_s = divrem_s && !funct3[0];
  end

  // Op-code mapping; unsigned divides are only sent when both operands are non-negative.
  always_comb begin
    op          = OP_MUL;
    supported_s = 1'b1;
    if (shift) begin
      case (funct3)
        F3_SLL:  op = OP_SLL;
        F3_SRL:  op = sra ? OP_SRA : OP_SRL;
        default: supported_s = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_MUL:    op = OP_MUL;
        F3_MULH:   op = OP_MULSH;
        F3_MULHSU: supported_s = 1'b0;
        F3_MULHU:  op = OP_MULH;
        F3_DIV:    op = OP_DIV;
        F3_DIVU: begin
          op          = OP_DIV;
          supported_s = !(a[31] || b[31]);
        end
        F3_REM:    op = OP_REM;
        F3_REMU: begin
          op          = OP_REM;
          supported_s = !(a[31] || b[31]);
        end
        default:   supported_s = 1'b0;
      endcase
    end
  end

  // Local completions in priority order: errors first, then the first matching value rule.
  always_comb begin
    is_local   = 1'b1;
    local_data = 32'h0000_0000;
    local_err  = 1'b0;
    if (!supported_s) begin
      local_err = 1'b1;
    end else if (rd == 5'd0) begin
      local_data = 32'h0000_0000;
    end else if (divrem_s && (b == 32'h0000_0000)) begin
      local_data = rem_s ? a : 32'hFFFF_FFFF;
    end else if (signed_div_s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      local_data = rem_s ? 32'h0000_0000 : 32'h8000_0000;
    end else if (shift && (b[4:0] == 5'd0)) begin
      local_data = a;
    end else begin
      is_local = 1'b0;
    end
  end

endmodule

// File: rtl/fwrisc_mds_issue.sv
// Issue FSM for the multiply/divide/shift unit: accepts one request, either
// completes it locally or issues it and waits (bounded) for the unit result.
module fwrisc_mds_issue
  import fwrisc_mds_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic               clock,
  input  logic               reset_n,
  fwrisc_mds_issue_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mds_state_e  state_r;
  logic        req_ready_r;
  logic        busy_r;
  logic        mds_valid_r;
  logic [3:0]  mds_op_r;
  logic [31:0] mds_a_r;
  logic [31:0] mds_b_r;
  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic        wb_err_r;
  logic [CW-1:0] wait_cnt_r;
  logic [CW-1:0] wait_cnt_next_s;

  logic [3:0]  dec_op_s;
  logic        dec_local_s;
  logic [31:0] dec_data_s;
  logic        dec_err_s;

  fwrisc_mds_decode u_decode (
    .shift      (bus.req_shift),
    .funct3     (bus.req_funct3),
    .sra        (bus.req_sra),
    .a          (bus.req_a),
    .b          (bus.req_b),
    .rd         (bus.req_rd),
    .op         (dec_op_s),
    .is_local   (dec_local_s),
    .local_data (dec_data_s),
    .local_err  (dec_err_s)
  );

  // Cycles spent in WAIT, counting the current one.
  always_comb begin
    wait_cnt_next_s = wait_cnt_r + CW'(1);
  end

  // Request/issue/wait/response state machine with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      mds_valid_r <= 1'b0;
      mds_op_r    <= 4'd0;
      mds_a_r     <= 32'h0000_0000;
      mds_b_r     <= 32'h0000_0000;
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_data_r   <= 32'h0000_0000;
      wb_err_r    <= 1'b0;
      wait_cnt_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            mds_a_r     <= bus.req_a;
            mds_b_r     <= bus.req_b;
            mds_op_r    <= dec_op_s;
            wb_rd_r     <= bus.req_rd;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (dec_local_s) begin
              state_r    <= ST_RESP;
              wb_valid_r <= 1'b1;
              wb_data_r  <= dec_data_s;
              wb_err_r   <= dec_err_s;
            end else begin
              state_r     <= ST_ISSUE;
              mds_valid_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          mds_valid_r <= 1'b0;
          wait_cnt_r  <= '0;
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.mds_out_valid) begin
            wb_data_r  <= bus.mds_out;
            wb_err_r   <= 1'b0;
            wb_valid_r <= 1'b1;
            state_r    <= ST_RESP;
          end else if (wait_cnt_next_s == CW'(TIMEOUT)) begin
            wb_data_r  <= 32'h0000_0000;
            wb_err_r   <= 1'b1;
            wb_valid_r <= 1'b1;
            wait_cnt_r <= wait_cnt_next_s;
            state_r    <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_next_s;
          end
        end
        ST_RESP: begin
          if (bus.wb_ready) begin
            wb_valid_r  <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          mds_valid_r <= 1'b0;
          wb_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.busy      = busy_r;
  assign bus.mds_valid = mds_valid_r;
  assign bus.mds_op    = mds_op_r;
  assign bus.mds_a     = mds_a_r;
  assign bus.mds_b     = mds_b_r;
  assign bus.wb_valid  = wb_valid_r;
  assign bus.wb_rd     = wb_rd_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.wb_err    = wb_err_r;

endmodule

// File: tb/tb_fwrisc_mds_issue.sv
// Randomized bench for fwrisc_mds_issue: RV32M/shift semantics model plus a
// behavioural execution unit that answers issued ops after a random delay.
module tb_fwrisc_mds_issue;
  import fwrisc_mds_pkg::*;

  localparam int TIMEOUT = 40;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  fwrisc_mds_issue_if bus ();

  fwrisc_mds_issue #(.TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Architectural result of the request, with the block's local-completion rules.
  task automatic ref_model(input logic shift, input logic [2:0] f3, input logic sra,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           output logic loc, output logic err, output logic [31:0] data,
                           output logic [3:0] op);
    logic [63:0] ps, pu;
    logic [31:0] val;
    logic bad, special;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    bad = 1'b0; special = 1'b0; val = 32'd0; op = OP_MUL;
    if (shift) begin
      if (f3 == 3'b001) begin
        val = a << b[4:0]; op = OP_SLL;
      end else if (f3 == 3'b101 && sra) begin
        val = $signed(a) >>> b[4:0]; op = OP_SRA;
      end else if (f3 == 3'b101) begin
        val = a >> b[4:0]; op = OP_SRL;
      end else begin
        bad = 1'b1;
      end
      special = (b[4:0] == 5'd0);
    end else begin
      case (f3)
        3'd0: begin val = pu[31:0];  op = OP_MUL;   end
        3'd1: begin val = ps[63:32]; op = OP_MULSH; end
        3'd2: bad = 1'b1;
        3'd3: begin val = pu[63:32]; op = OP_MULH;  end
        3'd4: begin
          op = OP_DIV;
          if (b == 32'd0) begin val = 32'hFFFF_FFFF; special = 1'b1; end
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin val = 32'h8000_0000; special = 1'b1; end
          else val = $signed(a) / $signed(b);
        end
        3'd5: begin
          op = OP_DIV;
          if (a[31] || b[31]) bad = 1'b1;
          else if (b == 32'd0) begin val = 32'hFFFF_FFFF; special = 1'b1; end
          else val = a / b;
        end
        3'd6: begin
          op = OP_REM;
          if (b == 32'd0) begin val = a; special = 1'b1; end
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin val = 32'd0; special = 1'b1; end
          else val = $signed(a) % $signed(b);
        end
        default: begin
          op = OP_REM;
          if (a[31] || b[31]) bad = 1'b1;
          else if (b == 32'd0) begin val = a; special = 1'b1; end
          else val = a % b;
        end
      endcase
    end
    err  = bad;
    loc  = bad || special || (rd == 5'd0);
    data = (bad || rd == 5'd0) ? 32'd0 : val;
  endtask

  // Behavioural execution unit keyed by op code.
  function automatic logic [31:0] unit_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ps, pu;
    logic [31:0] r;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      OP_SLL:   r = a << b[4:0];
      OP_SRL:   r = a >> b[4:0];
      OP_SRA:   r = $signed(a) >>> b[4:0];
      OP_MUL:   r = pu[31:0];
      OP_MULH:  r = pu[63:32];
      OP_MULSH: r = ps[63:32];
      OP_DIV:   r = $signed(a) / $signed(b);
      OP_REM:   r = $signed(a) % $signed(b);
      default:  r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  task automatic run_txn(input logic shift, input logic [2:0] f3, input logic sra,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input int delay, input bit respond, input int hold);
    logic loc, err;
    logic [31:0] data;
    logic [3:0] op;
    int cnt;
    ref_model(shift, f3, sra, a, b, rd, loc, err, data, op);
    cnt = 0;
    while (!bus.req_ready && cnt < 60) begin
      @(posedge clock); #1; cnt++;
    end
    chk("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_shift = shift; bus.req_funct3 = f3; bus.req_sra = sra;
    bus.req_a = a; bus.req_b = b; bus.req_rd = rd;
    @(posedge clock); #1;
    bus.req_valid = 1'b0; bus.req_a = $urandom; bus.req_b = $urandom;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    chk("req_ready_after_accept", {31'd0, bus.req_ready}, 32'd0);
    if (loc) begin
      chk("local_no_issue", {31'd0, bus.mds_valid}, 32'd0);
    end else begin
      chk("issue_pulse", {31'd0, bus.mds_valid}, 32'd1);
      chk("issue_op", {28'd0, bus.mds_op}, {28'd0, op});
      chk("issue_a", bus.mds_a, a);
      chk("issue_b", bus.mds_b, b);
      chk("no_wb_at_issue", {31'd0, bus.wb_valid}, 32'd0);
      @(posedge clock); #1;
      chk("issue_pulse_end", {31'd0, bus.mds_valid}, 32'd0);
      if (respond) begin
        repeat (delay) begin @(posedge clock); #1; end
        chk("no_wb_before_result", {31'd0, bus.wb_valid}, 32'd0);
        bus.mds_out = unit_calc(bus.mds_op, bus.mds_a, bus.mds_b);
        bus.mds_out_valid = 1'b1;
        @(posedge clock); #1;
        bus.mds_out_valid = 1'b0; bus.mds_out = $urandom;
      end else begin
        cnt = 0;
        while (!bus.wb_valid && cnt < TIMEOUT + 10) begin
          @(posedge clock); #1; cnt++;
        end
        chk("timeout_cycles", cnt, TIMEOUT);
        data = 32'd0; err = 1'b1;
      end
      chk("operand_a_held", bus.mds_a, a);
      chk("operand_b_held", bus.mds_b, b);
    end
    chk("wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, rd});
    chk("wb_data", bus.wb_data, data);
    chk("wb_err", {31'd0, bus.wb_err}, {31'd0, err});
    repeat (hold) begin
      bus.mds_out = $urandom; bus.mds_out_valid = 1'b1;
      @(posedge clock); #1;
      bus.mds_out_valid = 1'b0;
      chk("hold_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("hold_wb_data", bus.wb_data, data);
      chk("hold_wb_err", {31'd0, bus.wb_err}, {31'd0, err});
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.wb_ready = 1'b1;
    @(posedge clock); #1;
    bus.wb_ready = 1'b0;
    chk("wb_released", {31'd0, bus.wb_valid}, 32'd0);
    chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_not_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = $urandom_range(0, 40);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    n_vec = 0; n_bad = 0;
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_shift = 1'b0; bus.req_funct3 = 3'd0; bus.req_sra = 1'b0;
    bus.req_a = 32'd0; bus.req_b = 32'd0; bus.req_rd = 5'd0;
    bus.mds_out = 32'd0; bus.mds_out_valid = 1'b0; bus.wb_ready = 1'b0;
    #22;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mds_valid", {31'd0, bus.mds_valid}, 32'd0);
    chk("rst_mds_op", {28'd0, bus.mds_op}, 32'd0);
    chk("rst_mds_a", bus.mds_a, 32'd0);
    chk("rst_mds_b", bus.mds_b, 32'd0);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_err", {31'd0, bus.wb_err}, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    run_txn(1'b0, F3_MUL,    1'b0, 32'd7,         32'd6,         5'd3, 32, 1'b1, 0);
    run_txn(1'b0, F3_DIV,    1'b0, 32'd100,       32'd0,         5'd4, 0,  1'b1, 0);
    run_txn(1'b0, F3_REMU,   1'b0, 32'd5,         32'd0,         5'd5, 0,  1'b1, 0);
    run_txn(1'b0, F3_DIV,    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0,  1'b1, 0);
    run_txn(1'b0, F3_REM,    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0,  1'b1, 0);
    run_txn(1'b0, F3_MULHSU, 1'b0, 32'd9,         32'd3,         5'd8, 0,  1'b1, 0);
    run_txn(1'b0, F3_DIVU,   1'b0, 32'h8000_0000, 32'd3,         5'd9, 0,  1'b1, 0);
    run_txn(1'b1, F3_SRL,    1'b1, 32'hF000_0000, 32'd4,         5'd10, 0, 1'b0, 5);
    run_txn(1'b1, F3_SLL,    1'b0, 32'h1234_5678, 32'h20,        5'd11, 0, 1'b1, 0);
    run_txn(1'b0, F3_MUL,    1'b0, 32'd7,         32'd6,         5'd0, 0,  1'b1, 0);

    // Reset while waiting on the unit, then a stale result arrives.
    bus.req_valid = 1'b1; bus.req_shift = 1'b0; bus.req_funct3 = F3_MUL;
    bus.req_a = 32'd11; bus.req_b = 32'd13; bus.req_rd = 5'd2;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #2;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("midrst_mds_a", bus.mds_a, 32'd0);
    chk("midrst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    bus.mds_out = 32'd143; bus.mds_out_valid = 1'b1;
    @(posedge clock); #1;
    bus.mds_out_valid = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
      chk("stale_no_wb", {31'd0, bus.wb_valid}, 32'd0);
      chk("stale_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("stale_not_busy", {31'd0, bus.busy}, 32'd0);
    end

    for (int i = 0; i < 150; i++) begin
      logic shift_v;
      logic [4:0] rd_v;
      shift_v = ($urandom_range(0, 2) == 0);
      rd_v = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_txn(shift_v, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              rnd_opnd(), rnd_opnd(), rd_v,
              $urandom_range(0, TIMEOUT - 2), ($urandom_range(0, 9) != 0),
              $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
